// File: rtl/rx_ber_pkg.sv
// Shared constants and FSM state encoding for the receive-side BER checker.
package rx_ber_pkg;

  localparam int OVERSAMPLE   = 4;
  localparam int NB_PHASE     = 2;
  localparam int NB_INPUT_DEF = 8;
  localparam int N_DELAY_DEF  = 32;
  localparam int NB_DELAY_DEF = 5;
  localparam int WINDOW_DEF   = 511;
  localparam int NB_WIN_DEF   = 9;
  localparam int NB_CNT_DEF   = 64;
  localparam int LOSS_TH_DEF  = 16;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } ber_state_e;

endpackage

// File: rtl/rx_ber_checker_if.sv
// Sample/reference/control bundle of the BER checker; master drives stimulus, slave is the checker.
interface rx_ber_checker_if
  import rx_ber_pkg::*;
#(
  parameter int NB_INPUT = NB_INPUT_DEF,
  parameter int NB_DELAY = NB_DELAY_DEF,
  parameter int NB_CNT   = NB_CNT_DEF
) ();

  logic                i_enable;
  logic [NB_INPUT-1:0] i_data;
  logic [NB_PHASE-1:0] i_phase;
  logic                i_ref_bit;
  logic                i_clear_cnt;
  logic                o_bit;
  logic                o_bit_valid;
  logic                o_locked;
  logic [NB_DELAY-1:0] o_delay;
  logic [NB_CNT-1:0]   o_bit_count;
  logic [NB_CNT-1:0]   o_err_count;

  modport master (
    output i_enable, i_data, i_phase, i_ref_bit, i_clear_cnt,
    input  o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count
  );

  modport slave (
    input  i_enable, i_data, i_phase, i_ref_bit, i_clear_cnt,
    output o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count
  );

endinterface

// File: rtl/ber_delay_line.sv
// Reference bit history plus delay mux; tap 0 is the bit presented now, tap d the bit d strobes ago.
module ber_delay_line
  import rx_ber_pkg::*;
#(
  parameter int N_DELAY  = N_DELAY_DEF,
  parameter int NB_DELAY = NB_DELAY_DEF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_shift,
  input  logic                i_ref_bit,
  input  logic [NB_DELAY-1:0] i_delay,
  output logic                o_ref_sel
);

  logic [N_DELAY-1:1] hist_r;
  logic [N_DELAY-1:0] taps_s;

  // History shift register, newest bit at index 1.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      hist_r <= {(N_DELAY-1){1'b0}};
    end else if (i_shift) begin
      hist_r <= {hist_r[N_DELAY-2:1], i_ref_bit};
    end
  end

  assign taps_s    = {hist_r, i_ref_bit};
  assign o_ref_sel = taps_s[i_delay];

endmodule

// File: rtl/rx_ber_checker.sv
// Receive BER checker: decimate-by-4 sign slicer, delay search against a reference, locked BER counters.
// Optional build macro RX_BER_RELOCK_EN adds loss-of-lock detection and re-search while locked.
module rx_ber_checker
  import rx_ber_pkg::*;
#(
  parameter int NB_INPUT = NB_INPUT_DEF,
  parameter int N_DELAY  = N_DELAY_DEF,
  parameter int NB_DELAY = NB_DELAY_DEF,
  parameter int WINDOW   = WINDOW_DEF,
  parameter int NB_WIN   = NB_WIN_DEF,
  parameter int NB_CNT   = NB_CNT_DEF
) (
  input logic             clock,
  input logic             i_reset,
  rx_ber_checker_if.slave bus
);

  localparam logic [NB_WIN-1:0] WIN_ONES = {NB_WIN{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONES = {NB_CNT{1'b1}};

  logic [NB_PHASE-1:0] phase_cnt_r;
  ber_state_e          state_r, state_nxt_s;
  logic [NB_DELAY-1:0] delay_r, delay_nxt_s;
  logic [NB_WIN-1:0]   win_cnt_r, win_cnt_nxt_s;
  logic [NB_WIN-1:0]   win_err_r, win_err_nxt_s, win_err_inc_s;
  logic [NB_CNT-1:0]   bit_cnt_r, bit_cnt_nxt_s;
  logic [NB_CNT-1:0]   err_cnt_r, err_cnt_nxt_s;
  logic                bit_r, bit_valid_r, locked_r;
  logic                strobe_s, dec_s, ref_sel_s, mismatch_s, win_end_s;

  assign strobe_s   = bus.i_enable && (phase_cnt_r == bus.i_phase);
  assign dec_s      = ($signed(bus.i_data) >= $signed({NB_INPUT{1'b0}}));
  assign mismatch_s = dec_s ^ ref_sel_s;
  assign win_end_s  = (win_cnt_r == NB_WIN'(WINDOW-1));

  ber_delay_line #(
    .N_DELAY  (N_DELAY),
    .NB_DELAY (NB_DELAY)
  ) u_delay_line (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_shift   (strobe_s),
    .i_ref_bit (bus.i_ref_bit),
    .i_delay   (delay_r),
    .o_ref_sel (ref_sel_s)
  );

  // Oversampling phase counter, frozen while disabled.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_cnt_r <= {NB_PHASE{1'b0}};
    end else if (bus.i_enable) begin
      phase_cnt_r <= (phase_cnt_r == NB_PHASE'(OVERSAMPLE-1)) ? {NB_PHASE{1'b0}}
                                                              : phase_cnt_r + NB_PHASE'(1'b1);
    end
  end

  // Alignment FSM next state, delay and window counters; window error count includes this strobe.
  always_comb begin
    state_nxt_s   = state_r;
    delay_nxt_s   = delay_r;
    win_cnt_nxt_s = win_cnt_r;
    win_err_nxt_s = win_err_r;
    if (mismatch_s && (win_err_r != WIN_ONES)) begin
      win_err_inc_s = win_err_r + NB_WIN'(1'b1);
    end else begin
      win_err_inc_s = win_err_r;
    end
    if (strobe_s) begin
      case (state_r)
        SEARCH: begin
          if (win_end_s) begin
            win_cnt_nxt_s = {NB_WIN{1'b0}};
            win_err_nxt_s = {NB_WIN{1'b0}};
            if (win_err_inc_s == {NB_WIN{1'b0}}) begin
              state_nxt_s = LOCKED;
            end else begin
              delay_nxt_s = (delay_r == NB_DELAY'(N_DELAY-1)) ? {NB_DELAY{1'b0}}
                                                             : delay_r + NB_DELAY'(1'b1);
            end
          end else begin
            win_cnt_nxt_s = win_cnt_r + NB_WIN'(1'b1);
            win_err_nxt_s = win_err_inc_s;
          end
        end
        LOCKED: begin
`ifdef RX_BER_RELOCK_EN
          if (win_end_s) begin
            win_cnt_nxt_s = {NB_WIN{1'b0}};
            win_err_nxt_s = {NB_WIN{1'b0}};
            if (win_err_inc_s >= NB_WIN'(LOSS_TH_DEF)) begin
              state_nxt_s = SEARCH;
              delay_nxt_s = {NB_DELAY{1'b0}};
            end else begin
              state_nxt_s = LOCKED;
            end
          end else begin
            win_cnt_nxt_s = win_cnt_r + NB_WIN'(1'b1);
            win_err_nxt_s = win_err_inc_s;
          end
`else
          state_nxt_s = LOCKED;
`endif
        end
        default: begin
          state_nxt_s = SEARCH;
          delay_nxt_s = {NB_DELAY{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Saturating BER counters; a clear overrides a coincident strobe.
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    err_cnt_nxt_s = err_cnt_r;
    if (bus.i_clear_cnt) begin
      bit_cnt_nxt_s = {NB_CNT{1'b0}};
      err_cnt_nxt_s = {NB_CNT{1'b0}};
    end else if (strobe_s && (state_r == LOCKED)) begin
      if (bit_cnt_r != CNT_ONES) begin
        bit_cnt_nxt_s = bit_cnt_r + NB_CNT'(1'b1);
      end else begin
        bit_cnt_nxt_s = bit_cnt_r;
      end
      if (mismatch_s && (err_cnt_r != CNT_ONES)) begin
        err_cnt_nxt_s = err_cnt_r + NB_CNT'(1'b1);
      end else begin
        err_cnt_nxt_s = err_cnt_r;
      end
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
      err_cnt_nxt_s = err_cnt_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_r     <= SEARCH;
      delay_r     <= {NB_DELAY{1'b0}};
      win_cnt_r   <= {NB_WIN{1'b0}};
      win_err_r   <= {NB_WIN{1'b0}};
      bit_cnt_r   <= {NB_CNT{1'b0}};
      err_cnt_r   <= {NB_CNT{1'b0}};
      bit_r       <= 1'b0;
      bit_valid_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      delay_r     <= delay_nxt_s;
      win_cnt_r   <= win_cnt_nxt_s;
      win_err_r   <= win_err_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      bit_r       <= strobe_s ? dec_s : bit_r;
      bit_valid_r <= strobe_s;
      locked_r    <= (state_nxt_s == LOCKED);
    end
  end

  assign bus.o_bit       = bit_r;
  assign bus.o_bit_valid = bit_valid_r;
  assign bus.o_locked    = locked_r;
  assign bus.o_delay     = delay_r;
  assign bus.o_bit_count = bit_cnt_r;
  assign bus.o_err_count = err_cnt_r;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed bench for rx_ber_checker: reset, phase select, delay search, BER counting, clear, relock.
module tb_rx_ber_checker;
  import rx_ber_pkg::*;

  localparam int NREF = 16384;
  localparam int LIM  = 3000;
  localparam logic [7:0] POS = 8'h40;
  localparam logic [7:0] NEG = 8'hC0;

  logic clock = 1'b0;
  logic i_reset = 1'b0;
  always #5 clock = ~clock;

  rx_ber_checker_if bus ();

  rx_ber_checker dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  int         nvalid  = 0;
  int         nbad_bit = 0;
  int         sk = 0;
  int         dd = 0;
  logic [1:0] ph = 2'd0;
  logic [1:0] cur_phase = 2'd0;
  logic       refs [0:NREF-1];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One symbol = 4 enabled clocks; the sample on the selected phase carries b, the others carry ~b.
  task automatic sym(input logic b, input logic r, input logic clr);
    for (int k = 0; k < 4; k++) begin
      bus.i_enable  = 1'b1;
      bus.i_ref_bit = r;
      bus.i_phase   = cur_phase;
      if (ph == cur_phase) begin
        bus.i_data      = b ? POS : NEG;
        bus.i_clear_cnt = clr;
      end else begin
        bus.i_data      = b ? NEG : POS;
        bus.i_clear_cnt = 1'b0;
      end
      @(posedge clock);
      #1;
      ph = ph + 2'd1;
      if (bus.o_bit_valid) begin
        nvalid++;
        if (bus.o_bit !== b) nbad_bit++;
      end
    end
    bus.i_clear_cnt = 1'b0;
  endtask

  // Data follows the PRBS reference delayed by dd symbols.
  task automatic sym_auto(input logic flip, input logic clr);
    logic b;
    b = (sk >= dd) ? refs[sk-dd] : 1'b0;
    sym(b ^ flip, refs[sk], clr);
    sk++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (3) begin
      bus.i_enable    = 1'($urandom_range(0, 1));
      bus.i_data      = 8'($urandom);
      bus.i_phase     = 2'($urandom);
      bus.i_ref_bit   = 1'($urandom_range(0, 1));
      bus.i_clear_cnt = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    check_val("rst_bit",       64'(bus.o_bit),       64'd0);
    check_val("rst_valid",     64'(bus.o_bit_valid), 64'd0);
    check_val("rst_locked",    64'(bus.o_locked),    64'd0);
    check_val("rst_delay",     64'(bus.o_delay),     64'd0);
    check_val("rst_bit_count", bus.o_bit_count,      64'd0);
    check_val("rst_err_count", bus.o_err_count,      64'd0);
    i_reset         = 1'b0;
    bus.i_enable    = 1'b0;
    bus.i_clear_cnt = 1'b0;
    @(posedge clock);
    #1;
    check_val("post_rst_delay",  64'(bus.o_delay),  64'd0);
    check_val("post_rst_locked", 64'(bus.o_locked), 64'd0);
    ph = 2'd0;
  endtask

  initial begin
    logic [8:0] lfsr;
    int         e;
    int         n1;
    lfsr = 9'h1FF;
    for (int i = 0; i < NREF; i++) begin
      refs[i] = lfsr[8];
      lfsr    = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
    bus.i_enable = 1'b0; bus.i_data = 8'h00; bus.i_phase = 2'd0;
    bus.i_ref_bit = 1'b0; bus.i_clear_cnt = 1'b0;

    // Phase select: only phase 2 is positive, reference all ones.
    do_reset();
    cur_phase = 2'd2;
    nvalid = 0; nbad_bit = 0;
    repeat (510) sym(1'b1, 1'b1, 1'b0);
    check_val("ph_unlocked_510", 64'(bus.o_locked), 64'd0);
    sym(1'b1, 1'b1, 1'b0);
    check_val("ph_locked_511", 64'(bus.o_locked),    64'd1);
    check_val("ph_delay",      64'(bus.o_delay),     64'd0);
    check_val("ph_valid_cnt",  64'(nvalid),          64'd511);
    check_val("ph_bad_bits",   64'(nbad_bit),        64'd0);
    check_val("ph_bit_count",  bus.o_bit_count,      64'd0);

    // Delay search: data lags the PRBS reference by 7 symbols.
    do_reset();
    cur_phase = 2'd0;
    dd = 7; sk = 0;
    repeat (8*511-1) sym_auto(1'b0, 1'b0);
    check_val("ds_unlocked", 64'(bus.o_locked), 64'd0);
    check_val("ds_delay_pre", 64'(bus.o_delay), 64'd7);
    sym_auto(1'b0, 1'b0);
    check_val("ds_locked", 64'(bus.o_locked), 64'd1);
    check_val("ds_delay",  64'(bus.o_delay),  64'd7);

    // Error counting: 1000 locked symbols with 3 flipped samples.
    for (int i = 0; i < 1000; i++) sym_auto(1'((i == 10) || (i == 500) || (i == 999)), 1'b0);
    check_val("ec_bit_count", bus.o_bit_count, 64'd1000);
    check_val("ec_err_count", bus.o_err_count, 64'd3);

    // Disabled clocks freeze everything.
    bus.i_enable = 1'b0;
    bus.i_data   = POS;
    repeat (6) begin
      @(posedge clock);
      #1;
    end
    check_val("frz_bit_count", bus.o_bit_count,      64'd1000);
    check_val("frz_valid",     64'(bus.o_bit_valid), 64'd0);

    // Clear on a mismatching strobe wins; next strobe counts from zero.
    sym_auto(1'b1, 1'b1);
    check_val("clr_bit_count", bus.o_bit_count, 64'd0);
    check_val("clr_err_count", bus.o_err_count, 64'd0);
    sym_auto(1'b0, 1'b0);
    check_val("clr_next_bit", bus.o_bit_count, 64'd1);
    check_val("clr_next_err", bus.o_err_count, 64'd0);

    // Data alignment jumps to delay 3.
    dd = 3;
`ifdef RX_BER_RELOCK_EN
    e = 0; n1 = 0;
    while (bus.o_locked && (n1 < LIM)) begin
      if (refs[sk-3] != refs[sk-7]) e++;
      sym_auto(1'b0, 1'b0);
      n1++;
    end
    check_val("rl_loss_locked", 64'(bus.o_locked), 64'd0);
    check_val("rl_loss_delay",  64'(bus.o_delay),  64'd0);
    for (int n = 0; (n < LIM) && !bus.o_locked; n++) sym_auto(1'b0, 1'b0);
    check_val("rl_relocked",   64'(bus.o_locked), 64'd1);
    check_val("rl_delay",      64'(bus.o_delay),  64'd3);
    check_val("rl_bit_held",   bus.o_bit_count,   64'(1 + n1));
    check_val("rl_err_held",   bus.o_err_count,   64'(e));
`else
    e = 0; n1 = 0;
    repeat (511) begin
      if (refs[sk-3] != refs[sk-7]) e++;
      sym_auto(1'b0, 1'b0);
    end
    check_val("nl_locked",    64'(bus.o_locked), 64'd1);
    check_val("nl_delay",     64'(bus.o_delay),  64'd7);
    check_val("nl_bit_count", bus.o_bit_count,   64'd512);
    check_val("nl_err_count", bus.o_err_count,   64'(e));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
